// File: rtl/isa_pkg.sv
// ISA definitions shared by the decode front end: opcodes, IMSel codes, field positions,
// the decoded-entry record and the combinational field decoder.
package isa_pkg;

  localparam int OPC_W = 6;
  localparam int REG_W = 3;

  localparam int OPC_LSB = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 20;
  localparam int RC_LSB  = 17;

  localparam logic [OPC_W-1:0] OP_R    = 6'h00;
  localparam logic [OPC_W-1:0] OP_J    = 6'h02;
  localparam logic [OPC_W-1:0] OP_JAL  = 6'h03;
  localparam logic [OPC_W-1:0] OP_BEQ  = 6'h04;
  localparam logic [OPC_W-1:0] OP_ADDI = 6'h08;
  localparam logic [OPC_W-1:0] OP_LUI  = 6'h0F;
  localparam logic [OPC_W-1:0] OP_LW   = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW   = 6'h2B;

  typedef enum logic [1:0] {
    IMSEL_J    = 2'b00,
    IMSEL_LDST = 2'b01,
    IMSEL_BEQ  = 2'b10,
    IMSEL_ALU  = 2'b11
  } imsel_e;

  typedef enum logic [1:0] {
    FMT_R,
    FMT_J,
    FMT_I20,
    FMT_I14
  } fmt_e;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rc;
    logic [25:0]      im26;
    logic [19:0]      im20;
    logic [13:0]      im14;
    logic [19:0]      sinal_input;
    imsel_e           imsel;
    logic             use_imm;
    logic             illegal;
  } dec_entry_t;

  localparam int DEC_ENTRY_W = $bits(dec_entry_t);

  // An unknown opcode keeps its raw opcode and sets illegal; every other field stays 0.
  function automatic dec_entry_t decode_instr(input logic [31:0] instr);
    dec_entry_t e;
    fmt_e       fmt;
    logic       legal;
    e        = '0;
    fmt      = FMT_R;
    legal    = 1'b1;
    e.opcode = instr[OPC_LSB +: OPC_W];
    case (e.opcode)
      OP_R:           begin fmt = FMT_R;   e.imsel = IMSEL_J;    end
      OP_J, OP_JAL:   begin fmt = FMT_J;   e.imsel = IMSEL_J;    end
      OP_LW, OP_SW:   begin fmt = FMT_I20; e.imsel = IMSEL_LDST; end
      OP_BEQ:         begin fmt = FMT_I14; e.imsel = IMSEL_BEQ;  end
      OP_ADDI, OP_LUI: begin fmt = FMT_I20; e.imsel = IMSEL_ALU; end
      default:        legal = 1'b0;
    endcase
    if (!legal) begin
      e.illegal = 1'b1;
    end else begin
      e.use_imm     = (fmt != FMT_R);
      e.im26        = instr[25:0];
      e.im20        = instr[19:0];
      e.im14        = instr[13:0];
      e.sinal_input = instr[19:0];
      if (fmt != FMT_J) begin
        e.ra = instr[RA_LSB +: REG_W];
        e.rb = instr[RB_LSB +: REG_W];
      end
      if (fmt == FMT_R) begin
        e.rc = instr[RC_LSB +: REG_W];
      end
    end
    return e;
  endfunction

endpackage

// File: rtl/instr_field_decoder_if.sv
// Valid/ready bundle between instruction fetch, the field decoder and the extender/control.
interface instr_field_decoder_if;
  import isa_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic             out_valid;
  logic             out_ready;
  logic [OPC_W-1:0] opcode;
  logic [REG_W-1:0] ra;
  logic [REG_W-1:0] rb;
  logic [REG_W-1:0] rc;
  logic [25:0]      im26;
  logic [19:0]      im20;
  logic [13:0]      im14;
  logic [19:0]      sinal_input;
  logic [1:0]       imsel;
  logic             use_imm;
  logic             illegal;

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, opcode, ra, rb, rc, im26, im20, im14,
           sinal_input, imsel, use_imm, illegal
  );

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, opcode, ra, rb, rc, im26, im20, im14,
           sinal_input, imsel, use_imm, illegal
  );

endinterface

// File: rtl/skid_buffer2.sv
// Two-entry valid/ready skid buffer. Entry0 drives the output; entry1 absorbs one word
// while the output is stalled. in_ready is a decode of the occupancy register.
module skid_buffer2 #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_TWO
  } skid_state_e;

  skid_state_e      state, state_next;
  logic [WIDTH-1:0] entry0, entry1;
  logic             push, pop;
  logic             load0, shift0, load1;

  assign in_ready  = (state != SKID_TWO);
  assign out_valid = (state != SKID_EMPTY);
  assign out_data  = entry0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= SKID_EMPTY;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    load0      = 1'b0;
    shift0     = 1'b0;
    load1      = 1'b0;
    case (state)
      SKID_EMPTY: begin
        if (push) begin
          load0      = 1'b1;
          state_next = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (push && pop) begin
          load0 = 1'b1;
        end else if (push) begin
          load1      = 1'b1;
          state_next = SKID_TWO;
        end else if (pop) begin
          state_next = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (pop) begin
          shift0     = 1'b1;
          state_next = SKID_ONE;
        end
      end
      default: state_next = SKID_EMPTY;
    endcase
  end

  // Entry0 is cleared so the field outputs read 0 straight out of reset.
  always_ff @(posedge clock) begin
    if (reset)       entry0 <= '0;
    else if (load0)  entry0 <= in_data;
    else if (shift0) entry0 <= entry1;
  end

  // NOTE: entry1 has no reset: it is only read after being written, so it stays a plain register.
  always_ff @(posedge clock) begin
    if (load1) entry1 <= in_data;
  end

endmodule

// File: rtl/instr_field_decoder.sv
// Decode-stage front end: splits each fetched word into opcode, register and immediate
// fields, then registers them through a 2-entry skid buffer. Option: DECODE_TRAP_EN.
module instr_field_decoder
  import isa_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  instr_field_decoder_if.slave  bus
);

  dec_entry_t dec_raw;
  dec_entry_t entry_in;
  dec_entry_t out_entry;
  logic       skid_in_valid;
  logic       skid_in_ready;

  assign dec_raw = decode_instr(bus.instr);

`ifdef DECODE_TRAP_EN
  // Sticky trap: the illegal word itself goes through, nothing after it does until reset.
  logic trap_q;

  always_ff @(posedge clock) begin
    if (reset) trap_q <= 1'b0;
    else if (bus.in_valid && bus.in_ready && dec_raw.illegal) trap_q <= 1'b1;
  end

  assign entry_in      = dec_raw;
  assign skid_in_valid = bus.in_valid && !trap_q;
  assign bus.in_ready  = skid_in_ready && !trap_q;
`else
  // Unknown opcodes become a NOP so the pipeline never stalls on them.
  assign entry_in      = dec_raw.illegal ? '0 : dec_raw;
  assign skid_in_valid = bus.in_valid;
  assign bus.in_ready  = skid_in_ready;
`endif

  skid_buffer2 #(
    .WIDTH (DEC_ENTRY_W)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .in_data   (entry_in),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_entry)
  );

  assign bus.opcode      = out_entry.opcode;
  assign bus.ra          = out_entry.ra;
  assign bus.rb          = out_entry.rb;
  assign bus.rc          = out_entry.rc;
  assign bus.im26        = out_entry.im26;
  assign bus.im20        = out_entry.im20;
  assign bus.im14        = out_entry.im14;
  assign bus.sinal_input = out_entry.sinal_input;
  assign bus.imsel       = out_entry.imsel;
  assign bus.use_imm     = out_entry.use_imm;
  assign bus.illegal     = out_entry.illegal;

endmodule

// File: tb/tb_instr_field_decoder.sv
// Directed + short random bench for instr_field_decoder; expected entries are queued on
// acceptance and compared when the decoder hands them downstream.
module tb_instr_field_decoder;
  import isa_pkg::*;

  localparam int BUDGET = 32;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  dec_entry_t sb[$];
  dec_entry_t mon_exp;

  instr_field_decoder_if bus ();

  instr_field_decoder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference decode written from the opcode/format table.
  function automatic dec_entry_t ref_decode(input logic [31:0] w);
    dec_entry_t e;
    logic [5:0] op;
    bit legal, has_ab, has_c;
    e = '0;
    op = w[31:26];
    legal = 1; has_ab = 0; has_c = 0;
    case (op)
      6'h00:        begin has_ab = 1; has_c = 1; e.imsel = IMSEL_J; e.use_imm = 0; end
      6'h02, 6'h03: begin e.imsel = IMSEL_J;    e.use_imm = 1; end
      6'h23, 6'h2B: begin has_ab = 1; e.imsel = IMSEL_LDST; e.use_imm = 1; end
      6'h04:        begin has_ab = 1; e.imsel = IMSEL_BEQ;  e.use_imm = 1; end
      6'h08, 6'h0F: begin has_ab = 1; e.imsel = IMSEL_ALU;  e.use_imm = 1; end
      default:      legal = 0;
    endcase
    if (legal) begin
      e.opcode      = op;
      e.ra          = has_ab ? w[25:23] : 3'd0;
      e.rb          = has_ab ? w[22:20] : 3'd0;
      e.rc          = has_c  ? w[19:17] : 3'd0;
      e.im26        = w[25:0];
      e.im20        = w[19:0];
      e.im14        = w[13:0];
      e.sinal_input = w[19:0];
    end else begin
      e = '0;
`ifdef DECODE_TRAP_EN
      e.opcode  = op;
      e.illegal = 1'b1;
`endif
    end
    return e;
  endfunction

  function automatic dec_entry_t observed();
    dec_entry_t e;
    e.opcode      = bus.opcode;
    e.ra          = bus.ra;
    e.rb          = bus.rb;
    e.rc          = bus.rc;
    e.im26        = bus.im26;
    e.im20        = bus.im20;
    e.im14        = bus.im14;
    e.sinal_input = bus.sinal_input;
    e.imsel       = imsel_e'(bus.imsel);
    e.use_imm     = bus.use_imm;
    e.illegal     = bus.illegal;
    return e;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic send(input logic [31:0] w);
    bit done;
    done = 0;
    bus.in_valid = 1'b1;
    bus.instr    = w;
    for (int n = 0; n < BUDGET && !done; n++) begin
      if (bus.in_ready) begin
        sb.push_back(ref_decode(w));
        done = 1;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    check("send_accept", 128'(done), 128'(1));
  endtask

  task automatic drain();
    for (int n = 0; n < 4 * BUDGET && sb.size() != 0; n++) tick();
    check("drain_empty", 128'(sb.size()), 128'(0));
  endtask

  // Scoreboard: compare whatever the decoder hands over on the coming edge.
  always @(negedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 128'(sb.size()), 128'(1));
      end else begin
        mon_exp = sb.pop_front();
        check("sb_entry", 128'(observed()), 128'(mon_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  legal_ops [8];
    logic [31:0] w;
    bit          ok;
    legal_ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h0F, 6'h23, 6'h2B};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("rst_fields", 128'(observed()), 128'(0));
    reset = 1'b0;
    tick();

    // LW
    send(32'h8CAF_FFFF);
    check("lw_valid", 128'(bus.out_valid), 128'(1));
    check("lw_opcode", 128'(bus.opcode), 128'(6'h23));
    check("lw_ra", 128'(bus.ra), 128'(1));
    check("lw_rb", 128'(bus.rb), 128'(2));
    check("lw_im20", 128'(bus.im20), 128'(20'hFFFFF));
    check("lw_imsel", 128'(bus.imsel), 128'(2'b01));
    drain();

    // BEQ
    send(32'h1088_2001);
    check("beq_ra", 128'(bus.ra), 128'(1));
    check("beq_rb", 128'(bus.rb), 128'(0));
    check("beq_im14", 128'(bus.im14), 128'(14'h2001));
    check("beq_imsel", 128'(bus.imsel), 128'(2'b10));
    check("beq_use_imm", 128'(bus.use_imm), 128'(1));
    drain();

    // J then ADDI back-to-back, no bubble
    send(32'h0BFF_FFFF);
    check("j_valid", 128'(bus.out_valid), 128'(1));
    check("j_im26", 128'(bus.im26), 128'(26'h3FF_FFFF));
    check("j_imsel", 128'(bus.imsel), 128'(2'b00));
    send(32'h2030_0005);
    check("addi_valid", 128'(bus.out_valid), 128'(1));
    check("addi_sinal", 128'(bus.sinal_input), 128'(20'h00005));
    check("addi_imsel", 128'(bus.imsel), 128'(2'b11));
    drain();

    // Stall with three words offered
    bus.out_ready = 1'b0;
    send(32'h8C41_1234);
    send(32'hAC9A_BCDE);
    check("stall_in_ready", 128'(bus.in_ready), 128'(0));
    bus.in_valid = 1'b1;
    bus.instr    = 32'h3C7F_0001;
    for (int i = 0; i < 2; i++) begin
      check("stall_frozen", 128'(observed()), 128'(ref_decode(32'h8C41_1234)));
      check("stall_hold_ready", 128'(bus.in_ready), 128'(0));
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("ready_after_pop", 128'(bus.in_ready), 128'(1));
    check("second_word", 128'(observed()), 128'(ref_decode(32'hAC9A_BCDE)));
    sb.push_back(ref_decode(32'h3C7F_0001));
    tick();
    bus.in_valid = 1'b0;
    drain();

    // Reset with two entries held
    bus.out_ready = 1'b0;
    send(32'h0123_4567);
    send(32'h0C00_0042);
    check("full_valid", 128'(bus.out_valid), 128'(1));
    check("full_in_ready", 128'(bus.in_ready), 128'(0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    check("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("mid_rst_fields", 128'(observed()), 128'(0));
    bus.out_ready = 1'b1;
    tick();

    // Random legal traffic with random back-pressure
    for (int i = 0; i < 30; i++) begin
      w = {legal_ops[$urandom_range(0, 7)], 26'($urandom)};
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_valid  = 1'b1;
      bus.instr     = w;
      ok = 0;
      for (int n = 0; n < BUDGET && !ok; n++) begin
        if (bus.in_ready) begin
          sb.push_back(ref_decode(w));
          ok = 1;
        end else begin
          bus.out_ready = 1'b1;
        end
        tick();
      end
      bus.in_valid = 1'b0;
      check("rand_accept", 128'(ok), 128'(1));
    end
    bus.out_ready = 1'b1;
    drain();

    // Illegal opcode 0x3F
    send(32'hFC00_0ABC);
`ifdef DECODE_TRAP_EN
    check("trap_illegal", 128'(bus.illegal), 128'(1));
    drain();
    bus.in_valid = 1'b1;
    bus.instr    = 32'h8CAF_FFFF;
    for (int i = 0; i < 4; i++) begin
      check("trap_in_ready", 128'(bus.in_ready), 128'(0));
      tick();
    end
    bus.in_valid = 1'b0;
    check("trap_no_output", 128'(bus.out_valid), 128'(0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("trap_cleared", 128'(bus.in_ready), 128'(1));
`else
    check("nop_fields", 128'(observed()), 128'(0));
    check("nop_illegal", 128'(bus.illegal), 128'(0));
    drain();
    send(32'h2000_0001);
    check("after_nop_imsel", 128'(bus.imsel), 128'(2'b11));
    drain();
`endif

    check("sb_final_empty", 128'(sb.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
